instr_fetch_decode: RTL and testbench
=====================================

// Module: instr_fetch_decode
// PURPOSE
//  Fetch/decode stage directly upstream of alu_top: PC, instruction memory, 2-entry decoded queue.
//  Fetches 32-bit MIPS words from synchronous instruction memory.
//  Decodes each word to the ALU's instr_ID code (1..12) plus register indices and immediate.
//  Hands the result to the ALU over a valid/ready handshake; branch redirects flush all queued work.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC of the first fetch after reset
//  PC_STEP   4              PC increment per fetched word (bytes)
//  QDEPTH    2              decoded-queue entries, including fetches still in flight
// PORTS
//  clk             in   1   single clock; all state updates on posedge
//  reset           in   1   asynchronous, active-high
//  imem_req        out  1   fetch request; memory always accepts
//  imem_addr       out  32  fetch address; equals pc
//  imem_rdata      in   32  instruction word, valid the cycle after imem_req
//  redirect_valid  in   1   one-cycle pulse: flush and restart fetch at redirect_pc
//  redirect_pc     in   32  new PC
//  dec_valid       out  1   head queue entry is valid
//  dec_ready       in   1   ALU accepts the head entry
//  dec_ir          out  32  raw instruction word
//  dec_instr_ID    out  32  1 add, 2 sub, 3 addu, 4 subu, 5 addi, 6 addiu, 7 and, 8 or,
//                           9 andi, 10 ori, 11 sll, 12 srl, 0 illegal
//  dec_rs,dec_rt,dec_rd  out 5 each  ir[25:21], ir[20:16], ir[15:11]
//  dec_imm         out  32  ALU operand b for I-type/shift instructions (rules below)
//  dec_pc          out  32  PC of the head entry
//  dec_illegal     out  1   head entry has no supported encoding
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, queue empty, nothing in flight, state=RUN, epoch=0.
//   All dec_* outputs and imem_req read 0 during reset.
//  Fetch: imem_req = (state==RUN) && !redirect_valid && (count + inflight < QDEPTH).
//   When imem_req is high, pc += PC_STEP (32-bit modulo, wraps silently).
//   Each fetch is tagged with the current epoch.
//  Response: the cycle after a request, imem_rdata is decoded and pushed to the queue tail,
//   but only if its tag matches epoch; otherwise it is dropped.
//  Latency: request in cycle N gives dec_valid in cycle N+2.
//   After reset release, first imem_req is in cycle 0 and dec_valid rises in cycle 2.
//  Handshake: a pop occurs iff dec_valid && dec_ready.
//   A push and a pop may happen in the same cycle.
//   dec_* outputs stay stable while dec_valid && !dec_ready.
//  Full: count + inflight == QDEPTH keeps imem_req low, so no response is ever lost.
//  Empty: dec_valid=0; dec_* keep their last value (don't-care).
//  Decode, opcode 0: funct 20/21/22/23/24/25/00/02 hex -> 1/3/2/4/7/8/11/12.
//   Decode, opcode 08/09/0C/0D -> 5/6/9/10. Any other encoding -> 0 with dec_illegal=1.
//  Immediates: addi/addiu sign-extend ir[15:0]; andi/ori zero-extend ir[15:0].
//   sll/srl: dec_imm = {27'b0, ir[10:6]}. R-type arithmetic/logic: dec_imm=0.
//  FSM RUN -> HALT when an illegal word is pushed; fetching stops, the queue still drains.
//   HALT -> RUN only on redirect_valid.
//  Redirect, effective at the same posedge: queue emptied, epoch toggled, pc=redirect_pc, state=RUN.
//   Any response in flight is dropped. imem_req is low that cycle; the next cycle fetches redirect_pc.
//  Redirect + pop in the same cycle: redirect wins and the pop is discarded.
//  Redirect + response in the same cycle: the response is dropped.
//  Reset mid-operation aborts everything, and any late imem_rdata is ignored.
// STRUCTURE
//  cse_bubble_pkg (shared): instr_ID localparams ID_ADD..ID_SRL, ID_ILLEGAL=0,
//   OPC_RTYPE/OPC_ADDI/OPC_ADDIU/OPC_ANDI/OPC_ORI, FUNCT_* constants.
//  instr_decoder: purely combinational ir -> {instr_ID, rs, rt, rd, imm, illegal}.
//   alu_top reuses the same package codes.
//  Top level: pc register, inflight/epoch flags, QDEPTH-entry circular queue (head/tail/count), RUN/HALT FSM.
// TESTING
//  1. Reset, RESET_PC=0, dec_ready=1, memory holds add,sub,addi -> IDs 1,2,5 at dec_pc 0,4,8; first dec_valid in cycle 2.
//  2. addi $1,$2,-3 (0x2041FFFD) -> dec_imm=32'hFFFF_FFFD; ori 0xFFFF -> dec_imm=32'h0000_FFFF.
//  3. sll $3,$4,5 -> ID 11 with dec_imm=5; srl -> ID 12.
//  4. dec_ready=0 for 10 cycles -> at most 2 requests in flight, outputs stable, none lost.
//     Release -> in-order delivery.
//  5. redirect_pc=0x100 while the queue is full and a fetch is in flight
//     -> stale words never appear; next dec_pc is 0x100.
//  6. Word 0xFC000000 -> dec_illegal=1, ID 0, fetch halts.
//     Redirect to 0x40 resumes fetching; reset mid-stream restarts at RESET_PC.

Source files
------------

// File: rtl/cse_bubble_pkg.sv
// Encodings shared by the fetch/decode stage and alu_top: instruction IDs,
// MIPS opcode/funct fields, fetch FSM states and the decoded queue entry.
package cse_bubble_pkg;

  localparam logic [31:0] ID_ILLEGAL = 32'd0;
  localparam logic [31:0] ID_ADD     = 32'd1;
  localparam logic [31:0] ID_SUB     = 32'd2;
  localparam logic [31:0] ID_ADDU    = 32'd3;
  localparam logic [31:0] ID_SUBU    = 32'd4;
  localparam logic [31:0] ID_ADDI    = 32'd5;
  localparam logic [31:0] ID_ADDIU   = 32'd6;
  localparam logic [31:0] ID_AND     = 32'd7;
  localparam logic [31:0] ID_OR      = 32'd8;
  localparam logic [31:0] ID_ANDI    = 32'd9;
  localparam logic [31:0] ID_ORI     = 32'd10;
  localparam logic [31:0] ID_SLL     = 32'd11;
  localparam logic [31:0] ID_SRL     = 32'd12;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] instr_id;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } dec_entry_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational MIPS word -> ALU instr_ID, register indices and operand-b immediate.
module instr_decoder
  import cse_bubble_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [31:0] o_instr_id,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [31:0] o_imm,
  output logic        o_illegal
);

  logic [5:0] w_opc;
  logic [5:0] w_funct;

  assign w_opc   = i_ir[31:26];
  assign w_funct = i_ir[5:0];
  assign o_rs    = i_ir[25:21];
  assign o_rt    = i_ir[20:16];
  assign o_rd    = i_ir[15:11];

  // Opcode/funct lookup; anything unrecognised falls through to illegal with imm 0.
  always_comb begin
    o_instr_id = ID_ILLEGAL;
    o_imm      = 32'h0000_0000;
    o_illegal  = 1'b1;
    case (w_opc)
      OPC_RTYPE: begin
        o_illegal = 1'b0;
        case (w_funct)
          FUNCT_ADD:  o_instr_id = ID_ADD;
          FUNCT_ADDU: o_instr_id = ID_ADDU;
          FUNCT_SUB:  o_instr_id = ID_SUB;
          FUNCT_SUBU: o_instr_id = ID_SUBU;
          FUNCT_AND:  o_instr_id = ID_AND;
          FUNCT_OR:   o_instr_id = ID_OR;
          FUNCT_SLL: begin
            o_instr_id = ID_SLL;
            o_imm      = {27'd0, i_ir[10:6]};
          end
          FUNCT_SRL: begin
            o_instr_id = ID_SRL;
            o_imm      = {27'd0, i_ir[10:6]};
          end
          default: begin
            o_instr_id = ID_ILLEGAL;
            o_illegal  = 1'b1;
          end
        endcase
      end
      OPC_ADDI: begin
        o_instr_id = ID_ADDI;
        o_imm      = sext16(i_ir[15:0]);
        o_illegal  = 1'b0;
      end
      OPC_ADDIU: begin
        o_instr_id = ID_ADDIU;
        o_imm      = sext16(i_ir[15:0]);
        o_illegal  = 1'b0;
      end
      OPC_ANDI: begin
        o_instr_id = ID_ANDI;
        o_imm      = zext16(i_ir[15:0]);
        o_illegal  = 1'b0;
      end
      OPC_ORI: begin
        o_instr_id = ID_ORI;
        o_imm      = zext16(i_ir[15:0]);
        o_illegal  = 1'b0;
      end
      default: begin
        o_instr_id = ID_ILLEGAL;
        o_imm      = 32'h0000_0000;
        o_illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage feeding alu_top: PC, epoch-tagged single-cycle fetch, decoded
// circular queue with valid/ready output, and a RUN/HALT FSM stopped by illegal words.
module instr_fetch_decode
  import cse_bubble_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4,
  parameter int          QDEPTH   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_dec_valid,
  input  logic        i_dec_ready,
  output logic [31:0] o_dec_ir,
  output logic [31:0] o_dec_instr_ID,
  output logic [4:0]  o_dec_rs,
  output logic [4:0]  o_dec_rt,
  output logic [4:0]  o_dec_rd,
  output logic [31:0] o_dec_imm,
  output logic [31:0] o_dec_pc,
  output logic        o_dec_illegal
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [31:0] PC_INC = 32'(PC_STEP);

  logic [31:0]      r_pc;
  logic             r_epoch;
  logic             r_inflight;
  logic             r_inflight_epoch;
  logic [31:0]      r_inflight_pc;
  logic [0:0]       r_state;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  dec_entry_t       r_queue [QDEPTH];

  logic [OCC_W-1:0] w_occupancy;
  logic             w_req;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_dec_id;
  logic [4:0]       w_dec_rs;
  logic [4:0]       w_dec_rt;
  logic [4:0]       w_dec_rd;
  logic [31:0]      w_dec_imm;
  logic             w_dec_illegal;
  dec_entry_t       w_entry;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(QDEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // In-flight fetches count against capacity so every response has a free slot.
  assign w_occupancy = {1'b0, r_count} + OCC_W'(r_inflight);
  assign w_req  = !i_reset && (r_state == ST_RUN) && !i_redirect_valid
                  && (w_occupancy < OCC_W'(QDEPTH));
  assign w_push = r_inflight && (r_inflight_epoch == r_epoch) && !i_redirect_valid;
  assign w_pop  = (r_count != '0) && i_dec_ready && !i_redirect_valid;

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_pc;

  instr_decoder u_decoder (
    .i_ir       (i_imem_rdata),
    .o_instr_id (w_dec_id),
    .o_rs       (w_dec_rs),
    .o_rt       (w_dec_rt),
    .o_rd       (w_dec_rd),
    .o_imm      (w_dec_imm),
    .o_illegal  (w_dec_illegal)
  );

  // Assemble the queue entry for the response arriving this cycle.
  always_comb begin
    w_entry          = '0;
    w_entry.ir       = i_imem_rdata;
    w_entry.instr_id = w_dec_id;
    w_entry.rs       = w_dec_rs;
    w_entry.rt       = w_dec_rt;
    w_entry.rd       = w_dec_rd;
    w_entry.imm      = w_dec_imm;
    w_entry.pc       = r_inflight_pc;
    w_entry.illegal  = w_dec_illegal;
  end

  // Fetch side: pc, epoch, in-flight tag and the RUN/HALT state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc             <= RESET_PC;
      r_epoch          <= 1'b0;
      r_inflight       <= 1'b0;
      r_inflight_epoch <= 1'b0;
      r_inflight_pc    <= 32'h0000_0000;
      r_state          <= ST_RUN;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_inflight_epoch <= r_epoch;
        r_inflight_pc    <= r_pc;
      end
      if (i_redirect_valid) begin
        r_pc    <= i_redirect_pc;
        r_epoch <= ~r_epoch;
        r_state <= ST_RUN;
      end else begin
        if (w_req) begin
          r_pc <= r_pc + PC_INC;
        end
        if (w_push && w_entry.illegal) begin
          r_state <= ST_HALT;
        end
      end
    end
  end

  // Decoded queue: push at tail, pop at head; a redirect discards everything.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_queue[i] <= '0;
      end
    end else if (i_redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_queue[r_tail] <= w_entry;
        r_tail          <= next_ptr(r_tail);
      end
      if (w_pop) begin
        r_head <= next_ptr(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dec_valid    = (r_count != '0);
  assign o_dec_ir       = r_queue[r_head].ir;
  assign o_dec_instr_ID = r_queue[r_head].instr_id;
  assign o_dec_rs       = r_queue[r_head].rs;
  assign o_dec_rt       = r_queue[r_head].rt;
  assign o_dec_rd       = r_queue[r_head].rd;
  assign o_dec_imm      = r_queue[r_head].imm;
  assign o_dec_pc       = r_queue[r_head].pc;
  assign o_dec_illegal  = r_queue[r_head].illegal;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: memory words and their expected decodes
// are queued together; a negedge monitor checks every accepted output in order.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_ir;
  logic [31:0] dec_instr_ID;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_rd;
  logic [31:0] dec_imm;
  logic [31:0] dec_pc;
  logic        dec_illegal;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] id;
    logic [31:0] imm;
    logic        ill;
    logic        chk_imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] mem [0:255];
  int          tests = 0;
  int          fails = 0;
  int          n_popped = 0;

  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc, prev_ir, prev_id, prev_imm;

  always #5 clk = ~clk;

  instr_fetch_decode dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_rdata     (imem_rdata),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_dec_valid      (dec_valid),
    .i_dec_ready      (dec_ready),
    .o_dec_ir         (dec_ir),
    .o_dec_instr_ID   (dec_instr_ID),
    .o_dec_rs         (dec_rs),
    .o_dec_rt         (dec_rt),
    .o_dec_rd         (dec_rd),
    .o_dec_imm        (dec_imm),
    .o_dec_pc         (dec_pc),
    .o_dec_illegal    (dec_illegal)
  );

  // Synchronous instruction memory: data valid the cycle after the request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr[9:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h", name, act, req);
    end
  endtask

  // Load a memory word and queue its expected decode.
  task automatic exp_push(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] id,
                          input logic [31:0] imm, input logic ill, input logic chk_imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    exp_t e;
    mem[pc[9:2]] = ir;
    e.pc = pc; e.ir = ir; e.id = id; e.imm = imm; e.ill = ill;
    e.chk_imm = chk_imm; e.rs = rs; e.rt = rt; e.rd = rd;
    exp_q.push_back(e);
  endtask

  // Monitor: in-order scoreboard compare on each handshake, stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && dec_valid) begin
        check("stable_pc", dec_pc, prev_pc);
        check("stable_ir", dec_ir, prev_ir);
        check("stable_id", dec_instr_ID, prev_id);
        check("stable_imm", dec_imm, prev_imm);
      end
      if (dec_valid && dec_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got dec_pc %08h ir %08h, expected no output", dec_pc, dec_ir);
        end else begin
          e = exp_q.pop_front();
          check("dec_pc", dec_pc, e.pc);
          check("dec_ir", dec_ir, e.ir);
          check("dec_instr_ID", dec_instr_ID, e.id);
          check("dec_illegal", 32'(dec_illegal), 32'(e.ill));
          check("dec_rs", 32'(dec_rs), 32'(e.rs));
          check("dec_rt", 32'(dec_rt), 32'(e.rt));
          check("dec_rd", 32'(dec_rd), 32'(e.rd));
          if (e.chk_imm) check("dec_imm", dec_imm, e.imm);
          n_popped++;
        end
      end
      prev_hold = dec_valid && !dec_ready && !redirect_valid;
      prev_pc = dec_pc; prev_ir = dec_ir; prev_id = dec_instr_ID; prev_imm = dec_imm;
    end
  end

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d entries outstanding after %0d cycles, expected 0", exp_q.size(), budget);
    end
  endtask

  task automatic check_halted(input string name);
    repeat (5) begin
      @(posedge clk);
      #1 check(name, 32'(imem_req), 32'd0);
    end
  endtask

  // Reset, then run the program at 0x00 until the illegal word halts fetch.
  task automatic run_from_reset();
    reset = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_id", dec_instr_ID, 32'h0);
    exp_q.delete();
    exp_push(32'h00, 32'h0022_1820, 32'd1,  32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    exp_push(32'h04, 32'h0022_1822, 32'd2,  32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    exp_push(32'h08, 32'h2041_FFFD, 32'd5,  32'hFFFF_FFFD, 1'b0, 1'b1, 5'd2, 5'd1, 5'd31);
    exp_push(32'h0C, 32'h3441_FFFF, 32'd10, 32'h0000_FFFF, 1'b0, 1'b1, 5'd2, 5'd1, 5'd31);
    exp_push(32'h10, 32'h0004_1940, 32'd11, 32'h0000_0005, 1'b0, 1'b1, 5'd0, 5'd4, 5'd3);
    exp_push(32'h14, 32'h0004_19C2, 32'd12, 32'h0000_0007, 1'b0, 1'b1, 5'd0, 5'd4, 5'd3);
    exp_push(32'h18, 32'h0022_1821, 32'd3,  32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    exp_push(32'h1C, 32'h0022_1823, 32'd4,  32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    exp_push(32'h20, 32'h0022_1824, 32'd7,  32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    exp_push(32'h24, 32'h0022_1825, 32'd8,  32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    exp_push(32'h28, 32'h2441_7FFF, 32'd6,  32'h0000_7FFF, 1'b0, 1'b1, 5'd2, 5'd1, 5'd15);
    exp_push(32'h2C, 32'h3041_8000, 32'd9,  32'h0000_8000, 1'b0, 1'b1, 5'd2, 5'd1, 5'd16);
    exp_push(32'h30, 32'hFC00_0000, 32'd0,  32'h0000_0000, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    exp_push(32'h34, 32'h0022_1820, 32'd1,  32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("cyc0_imem_req", 32'(imem_req), 32'd1);
    check("cyc0_imem_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1 check("cyc1_dec_valid", 32'(dec_valid), 32'd0);
    @(posedge clk);
    #1 check("cyc2_dec_valid", 32'(dec_valid), 32'd1);
    wait_drain(200);
    check_halted("halt_imem_req");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    int k;
    int target;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    reset = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Program at 0x00: all twelve IDs, immediates, illegal halt.
    run_from_reset();

    // Redirect out of HALT to 0x40 with the consumer stalled.
    exp_push(32'h40, 32'h0022_1820, 32'd1, 32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    exp_push(32'h44, 32'h0022_1822, 32'd2, 32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    exp_push(32'h48, 32'h2441_FFFF, 32'd6, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd2, 5'd1, 5'd31);
    exp_push(32'h4C, 32'h0022_1825, 32'd8, 32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    exp_push(32'h50, 32'h0022_1803, 32'd0, 32'h0000_0000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
    exp_push(32'h54, 32'h0022_1820, 32'd1, 32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    dec_ready = 1'b0;
    @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1 check("redir_imem_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    #1;
    check("post_redir_req", 32'(imem_req), 32'd1);
    check("post_redir_addr", imem_addr, 32'h40);
    nreq = 1;
    repeat (10) begin
      @(posedge clk);
      #1 if (imem_req) nreq++;
    end
    check("stall_requests", 32'(nreq), 32'd2);
    check("stall_dec_valid", 32'(dec_valid), 32'd1);
    check("stall_dec_pc", dec_pc, 32'h40);
    dec_ready = 1'b1;
    wait_drain(200);
    check_halted("halt2_imem_req");

    // Redirect to 0x100 while one word is queued and one is in flight.
    mem[32'h80 >> 2] = 32'h0022_1820;
    mem[32'h84 >> 2] = 32'h0022_1822;
    exp_push(32'h100, 32'h0022_1824, 32'd7, 32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    exp_push(32'h104, 32'hFC00_0000, 32'd0, 32'h0000_0000, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    dec_ready = 1'b0;
    @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    #1 check("fetch80_addr", imem_addr, 32'h80);
    @(posedge clk);
    #1 check("fetch84_addr", imem_addr, 32'h84);
    @(posedge clk);
    #1;
    check("full_dec_valid", 32'(dec_valid), 32'd1);
    check("full_dec_pc", dec_pc, 32'h80);
    check("full_imem_req", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h100; dec_ready = 1'b1;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    #1;
    check("flush_dec_valid", 32'(dec_valid), 32'd0);
    check("refetch_req", 32'(imem_req), 32'd1);
    check("refetch_addr", imem_addr, 32'h100);
    wait_drain(200);
    check_halted("halt3_imem_req");

    // Reset mid-stream: restart from RESET_PC, late responses ignored.
    exp_push(32'h40, 32'h0022_1820, 32'd1, 32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    exp_push(32'h44, 32'h0022_1822, 32'd2, 32'h0000_0000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    exp_push(32'h48, 32'h2441_FFFF, 32'd6, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd2, 5'd1, 5'd31);
    target = n_popped + 2;
    @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    k = 0;
    while (n_popped < target && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("midstream_pops", 32'(n_popped >= target), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_req", 32'(imem_req), 32'd0);
    check("async_rst_valid", 32'(dec_valid), 32'd0);
    exp_q.delete();
    run_from_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
